// File: rtl/somador_serial_4b.sv
// Bit-serial adder/subtractor: operands are captured on start and summed LSB-first,
// one bit per clock; the result nibble is held until the next operation completes.
module somador_serial_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] soma,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_sum;
  logic             w_carry;
  logic             w_last;
  logic             w_accept;
  logic             w_finish;

  // Subtraction is A + ~B + 1: invert B at capture, force the carry-in to 1.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_b_eff
      assign w_b_eff[gi] = op_b[gi] ^ sub;
    end
  endgenerate

  assign w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      soma    <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= w_finish;
      if (w_accept) begin
        r_a     <= op_a;
        r_b     <= w_b_eff;
        r_carry <= sub | cin;
        r_cnt   <= '0;
        r_res   <= '0;
        busy    <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_carry;
        r_res   <= {w_sum, r_res[WIDTH-1:1]};
        r_cnt   <= r_cnt + 1'b1;
        // Outputs move only here, so the downstream decoder never sees a partial sum.
        if (w_finish) begin
          soma <= {w_sum, r_res[WIDTH-1:1]};
          cout <= w_carry;
          ovf  <= r_carry ^ w_carry;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_somador_serial_4b.sv
// Directed and random operations against an integer-arithmetic reference model,
// checking busy/done timing, result hold, start masking, back-to-back and reset abort.
module tb_somador_serial_4b;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] soma;
  logic         cout;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] held_soma = '0;
  logic         held_cout = 1'b0;
  logic         held_ovf  = 1'b0;

  somador_serial_4b #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .op_a (op_a),
    .op_b (op_b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .soma (soma),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  task automatic ref_model(input int a, input int b, input bit s, input bit ci,
                           output logic [W-1:0] r, output logic co, output logic ov);
    int sa, sb, usum, ssum;
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    if (s) begin
      usum = a + ((1 << W) - 1 - b) + 1;
      ssum = sa - sb;
    end else begin
      usum = a + b + int'(ci);
      ssum = sa + sb + int'(ci);
    end
    r  = W'(usum % (1 << W));
    co = (usum >= (1 << W));
    ov = (ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1)));
  endtask

  // Called at a negedge with the DUT idle or in its DONE cycle; returns at the
  // negedge of the DONE cycle of this operation.
  task automatic run_op(input int a, input int b, input bit s, input bit ci);
    logic [W-1:0] er;
    logic         ec, eo;
    ref_model(a, b, s, ci, er, ec, eo);
    op_a  = W'(a);
    op_b  = W'(b);
    sub   = s;
    cin   = ci;
    start = 1'b1;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      // Scramble inputs and toggle start while busy: none of it may matter.
      start = 1'($urandom_range(0, 1));
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      sub   = 1'($urandom_range(0, 1));
      cin   = 1'($urandom_range(0, 1));
      check($sformatf("busy_c%0d", k), busy, 1'b1);
      check($sformatf("done_c%0d", k), done, 1'b0);
      check($sformatf("hold_c%0d", k), {cout, ovf, 2'b00, soma}, {held_cout, held_ovf, 2'b00, held_soma});
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 1'b1);
    check("busy_end", busy, 1'b0);
    check("soma", soma, er);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    held_soma = er;
    held_cout = ec;
    held_ovf  = eo;
    $display("op a=%0d b=%0d sub=%0d cin=%0d -> soma=%0h cout=%0d ovf=%0d (ref %0h %0d %0d)",
             a, b, s, ci, soma, cout, ovf, er, ec, eo);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("done_drop", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_soma", soma, 4'h0);
    check("rst_flags", {cout, ovf}, 2'b00);
    rst = 1'b0;
    idle_cycle();

    // Directed cases from the datapath bring-up list.
    run_op(7, 5, 1'b0, 1'b0); idle_cycle();
    run_op(9, 8, 1'b0, 1'b0); idle_cycle();
    run_op(7, 1, 1'b0, 1'b0); idle_cycle();
    run_op(3, 5, 1'b1, 1'b0); idle_cycle();
    run_op(5, 3, 1'b1, 1'b0); idle_cycle();
    run_op(15, 0, 1'b0, 1'b1); idle_cycle();
    run_op(8, 1, 1'b1, 1'b1); idle_cycle();
    run_op(0, 0, 1'b1, 1'b0); idle_cycle();

    // Back-to-back: the next start is presented in the DONE cycle.
    run_op(2, 3, 1'b0, 1'b0);
    run_op(4, 4, 1'b0, 1'b0);
    idle_cycle();

    // Reset mid-operation after a completed result of 12.
    run_op(7, 5, 1'b0, 1'b0); idle_cycle();
    op_a  = 4'd9;
    op_b  = 4'd8;
    sub   = 1'b0;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_soma", soma, 4'h0);
    check("abort_flags", {cout, ovf}, 2'b00);
    held_soma = '0;
    held_cout = 1'b0;
    held_ovf  = 1'b0;
    repeat (W + 1) idle_cycle();
    check("abort_soma_hold", soma, 4'h0);
    run_op(6, 7, 1'b0, 1'b1); idle_cycle();

    // Random operations, randomly back-to-back or with idle gaps.
    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
